// File: rtl/mem_stage_pkg.sv
// Shared MEM/EX definitions: opcodes, fault codes, reset PC, data memory geometry.
// Also provides the opcode-to-memory-operation decoder used by both stages.
package mem_stage_pkg;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   localparam logic [1:0] EXC_NONE  = 2'b00;
   localparam logic [1:0] EXC_LOAD  = 2'b01;
   localparam logic [1:0] EXC_STORE = 2'b10;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DM_LIMIT = 32'h0000_3000;
   localparam int          DM_DEPTH = 1024;
   localparam int          DM_AW    = 10;

   typedef enum logic [3:0] {
      M_NONE, M_LW, M_LH, M_LHU, M_LB, M_LBU, M_SW, M_SH, M_SB
   } mem_op_e;

   function automatic mem_op_e decode_op(input logic [5:0] opc);
      mem_op_e op;
      case (opc)
         OP_LW:   op = M_LW;
         OP_LH:   op = M_LH;
         OP_LHU:  op = M_LHU;
         OP_LB:   op = M_LB;
         OP_LBU:  op = M_LBU;
         OP_SW:   op = M_SW;
         OP_SH:   op = M_SH;
         OP_SB:   op = M_SB;
         default: op = M_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
// master drives the MEM side, slave is the stage itself.
interface mem_stage_if;
   logic [31:0] ins_MEM;
   logic [31:0] pc_MEM;
   logic [31:0] alu_MEM;
   logic [31:0] o2_MEM;
   logic [4:0]  rd_MEM;
   logic [1:0]  Tnew_MEM;

   logic [31:0] ins_WB;
   logic [31:0] pc_WB;
   logic [31:0] alu_WB;
   logic [31:0] dm_WB;
   logic [4:0]  rd_WB;
   logic [1:0]  Tnew_WB;
   logic [1:0]  exc_WB;

   modport master (
      output ins_MEM, pc_MEM, alu_MEM, o2_MEM, rd_MEM, Tnew_MEM,
      input  ins_WB, pc_WB, alu_WB, dm_WB, rd_WB, Tnew_WB, exc_WB
   );

   modport slave (
      input  ins_MEM, pc_MEM, alu_MEM, o2_MEM, rd_MEM, Tnew_MEM,
      output ins_WB, pc_WB, alu_WB, dm_WB, rd_WB, Tnew_WB, exc_WB
   );
endinterface

// File: rtl/mem_stage_dm_ram.sv
// Data memory: 32-bit words with per-byte write lanes, async read.
// Contents are not reset.
module dm_ram
   import mem_stage_pkg::*;
(
   input  logic             clk,
   input  logic [3:0]       we,
   input  logic [DM_AW-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DM_DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store decode, fault detection, load extension
// and the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   mem_stage_if.slave bus
);

   mem_op_e     op;
   logic [31:0] addr;
   logic        is_load;
   logic        is_store;
   logic        misalign;
   logic        fault;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] ld_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [1:0]  exc;
   logic [1:0]  tnew_nx;

   assign op   = decode_op(bus.ins_MEM[31:26]);
   assign addr = bus.alu_MEM;

   assign is_load  = op inside {M_LW, M_LH, M_LHU, M_LB, M_LBU};
   assign is_store = op inside {M_SW, M_SH, M_SB};

   always_comb begin
      misalign = 1'b0;
      case (op)
         M_LW, M_SW:        misalign = addr[1:0] != 2'b00;
         M_LH, M_LHU, M_SH: misalign = addr[0];
         default:           misalign = 1'b0;
      endcase
   end

   assign fault = (is_load || is_store) && (misalign || addr >= DM_LIMIT);

   // clr gates the lanes so a store in flight when reset hits is dropped
   always_comb begin
      we    = 4'b0000;
      wdata = 32'h0;
      if (is_store && !fault && clr) begin
         case (op)
            M_SW: begin
               we    = 4'b1111;
               wdata = bus.o2_MEM;
            end
            M_SH: begin
               we    = addr[1] ? 4'b1100 : 4'b0011;
               wdata = {2{bus.o2_MEM[15:0]}};
            end
            M_SB: begin
               we    = 4'b0001 << addr[1:0];
               wdata = {4{bus.o2_MEM[7:0]}};
            end
            default: begin
               we    = 4'b0000;
               wdata = 32'h0;
            end
         endcase
      end
   end

   dm_ram u_dm (
      .clk   (clk),
      .we    (we),
      .addr  (addr[DM_AW+1:2]),
      .wdata (wdata),
      .rdata (rdata)
   );

   assign byte_sel = rdata[{addr[1:0], 3'b000} +: 8];
   assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      ld_data = 32'h0;
      if (!fault) begin
         case (op)
            M_LW:    ld_data = rdata;
            M_LH:    ld_data = {{16{half_sel[15]}}, half_sel};
            M_LHU:   ld_data = {16'h0, half_sel};
            M_LB:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            M_LBU:   ld_data = {24'h0, byte_sel};
            default: ld_data = 32'h0;
         endcase
      end
   end

   always_comb begin
      exc = EXC_NONE;
      if (fault) exc = is_load ? EXC_LOAD : EXC_STORE;
   end

   assign tnew_nx = (bus.Tnew_MEM != 2'd0) ? bus.Tnew_MEM - 2'd1 : 2'd0;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         bus.ins_WB  <= 32'h0;
         bus.pc_WB   <= RESET_PC;
         bus.alu_WB  <= 32'h0;
         bus.dm_WB   <= 32'h0;
         bus.rd_WB   <= 5'd0;
         bus.Tnew_WB <= 2'd0;
         bus.exc_WB  <= EXC_NONE;
      end else begin
         bus.ins_WB  <= bus.ins_MEM;
         bus.pc_WB   <= bus.pc_MEM;
         bus.alu_WB  <= bus.alu_MEM;
         bus.dm_WB   <= ld_data;
         bus.rd_WB   <= bus.rd_MEM;
         bus.Tnew_WB <= tnew_nx;
         bus.exc_WB  <= exc;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected WB bundles.
// One instruction is issued per cycle and checked one cycle later.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk;
   logic clr;

   mem_stage_if bus ();

   mem_stage dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] dm;
      logic [4:0]  rd;
      logic [1:0]  tnew;
      logic [1:0]  exc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests;
   int          n_fail;
   logic [31:0] pc_cnt;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   task automatic drive_idle();
      bus.ins_MEM  = 32'h0;
      bus.pc_MEM   = 32'h0;
      bus.alu_MEM  = 32'h0;
      bus.o2_MEM   = 32'h0;
      bus.rd_MEM   = 5'd0;
      bus.Tnew_MEM = 2'd0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".ins"},  bus.ins_WB, 32'h0);
      check({tag, ".pc"},   bus.pc_WB, 32'h0000_3000);
      check({tag, ".alu"},  bus.alu_WB, 32'h0);
      check({tag, ".dm"},   bus.dm_WB, 32'h0);
      check({tag, ".rd"},   {27'h0, bus.rd_WB}, 32'h0);
      check({tag, ".tnew"}, {30'h0, bus.Tnew_WB}, 32'h0);
      check({tag, ".exc"},  {30'h0, bus.exc_WB}, 32'h0);
   endtask

   task automatic issue(input string tag, input logic [5:0] opc,
                        input logic [31:0] alu, input logic [31:0] o2,
                        input logic [1:0] tnew, input logic [31:0] exp_dm,
                        input logic [1:0] exp_exc, input logic [1:0] exp_tnew);
      exp_t e;
      exp_t g;
      @(negedge clk);
      pc_cnt       = pc_cnt + 32'd4;
      bus.ins_MEM  = {opc, 26'h15A_5A5A};
      bus.pc_MEM   = pc_cnt;
      bus.alu_MEM  = alu;
      bus.o2_MEM   = o2;
      bus.rd_MEM   = pc_cnt[6:2];
      bus.Tnew_MEM = tnew;
      e.tag  = tag;
      e.ins  = {opc, 26'h15A_5A5A};
      e.pc   = pc_cnt;
      e.alu  = alu;
      e.dm   = exp_dm;
      e.rd   = pc_cnt[6:2];
      e.tnew = exp_tnew;
      e.exc  = exp_exc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_empty"}, 32'h1, 32'h0);
      end else begin
         g = sb_q.pop_front();
         check({g.tag, ".ins"},  bus.ins_WB, g.ins);
         check({g.tag, ".pc"},   bus.pc_WB, g.pc);
         check({g.tag, ".alu"},  bus.alu_WB, g.alu);
         check({g.tag, ".dm"},   bus.dm_WB, g.dm);
         check({g.tag, ".rd"},   {27'h0, bus.rd_WB}, {27'h0, g.rd});
         check({g.tag, ".tnew"}, {30'h0, bus.Tnew_WB}, {30'h0, g.tnew});
         check({g.tag, ".exc"},  {30'h0, bus.exc_WB}, {30'h0, g.exc});
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      pc_cnt  = 32'h0000_3000;
      drive_idle();
      clr = 1'b1;
      #2 clr = 1'b0;
      #1 check_reset("rst_async");
      repeat (2) @(posedge clk);
      #1 check_reset("rst_hold");
      @(negedge clk);
      clr = 1'b1;

      // word round trip
      issue("sw_10", OP_SW, 32'h10, 32'hDEAD_BEEF, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("lw_10", OP_LW, 32'h10, 32'h0, 2'd0, 32'hDEAD_BEEF, 2'b00, 2'd0);

      // sub-word on word 0x10 -> 0x80ADBEEF
      issue("sb_13", OP_SB, 32'h13, 32'h1234_5680, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("lb_13", OP_LB, 32'h13, 32'h0, 2'd0, 32'hFFFF_FF80, 2'b00, 2'd0);
      issue("lbu_13", OP_LBU, 32'h13, 32'h0, 2'd0, 32'h0000_0080, 2'b00, 2'd0);
      issue("lh_12", OP_LH, 32'h12, 32'h0, 2'd0, 32'hFFFF_80AD, 2'b00, 2'd0);
      issue("lhu_10", OP_LHU, 32'h10, 32'h0, 2'd0, 32'h0000_BEEF, 2'b00, 2'd0);
      issue("lbu_11", OP_LBU, 32'h11, 32'h0, 2'd0, 32'h0000_00BE, 2'b00, 2'd0);
      issue("lw_10b", OP_LW, 32'h10, 32'h0, 2'd0, 32'h80AD_BEEF, 2'b00, 2'd0);

      // faults
      issue("sw_04", OP_SW, 32'h4, 32'hCAFE_F00D, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("sw_06f", OP_SW, 32'h6, 32'h1111_1111, 2'd0, 32'h0, 2'b10, 2'd0);
      issue("lw_04", OP_LW, 32'h4, 32'h0, 2'd0, 32'hCAFE_F00D, 2'b00, 2'd0);
      issue("lh_11f", OP_LH, 32'h11, 32'h0, 2'd0, 32'h0, 2'b01, 2'd0);
      issue("lw_3000f", OP_LW, 32'h3000, 32'h0, 2'd0, 32'h0, 2'b01, 2'd0);
      issue("lw_hi_f", OP_LW, 32'h0001_0010, 32'h0, 2'd0, 32'h0, 2'b01, 2'd0);
      issue("sw_2ffc", OP_SW, 32'h2FFC, 32'hA5A5_5A5A, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("lw_2ffc", OP_LW, 32'h2FFC, 32'h0, 2'd0, 32'hA5A5_5A5A, 2'b00, 2'd0);
      issue("sw_00", OP_SW, 32'h0, 32'h0000_0077, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("sb_3000f", OP_SB, 32'h3000, 32'hFFFF_FFEE, 2'd0, 32'h0, 2'b10, 2'd0);
      issue("sh_01f", OP_SH, 32'h1, 32'hFFFF_FFEE, 2'd0, 32'h0, 2'b10, 2'd0);
      issue("lw_00", OP_LW, 32'h0, 32'h0, 2'd0, 32'h0000_0077, 2'b00, 2'd0);

      // Tnew, non-memory op
      issue("tnew_2", 6'b000000, 32'h10, 32'h0, 2'd2, 32'h0, 2'b00, 2'd1);
      issue("tnew_0", 6'b001000, 32'h3001, 32'h0, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("tnew_3", 6'b000000, 32'h0, 32'h0, 2'd3, 32'h0, 2'b00, 2'd2);
      issue("tnew_1", OP_LW, 32'h4, 32'h0, 2'd1, 32'hCAFE_F00D, 2'b00, 2'd0);

      // back-to-back halves
      issue("sh_20", OP_SH, 32'h20, 32'hAAAA_1234, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("sh_22", OP_SH, 32'h22, 32'hBBBB_5678, 2'd0, 32'h0, 2'b00, 2'd0);
      issue("lw_20", OP_LW, 32'h20, 32'h0, 2'd0, 32'h5678_1234, 2'b00, 2'd0);

      // reset in the middle of a store
      @(negedge clk);
      bus.ins_MEM  = {OP_SW, 26'h0};
      bus.pc_MEM   = 32'h0000_4444;
      bus.alu_MEM  = 32'h10;
      bus.o2_MEM   = 32'h9999_9999;
      bus.rd_MEM   = 5'd9;
      bus.Tnew_MEM = 2'd2;
      #2 clr = 1'b0;
      #1 check_reset("rst_mid");
      @(posedge clk);
      #1 check_reset("rst_mid_edge");
      @(negedge clk);
      drive_idle();
      clr = 1'b1;
      issue("lw_10_rst", OP_LW, 32'h10, 32'h0, 2'd0, 32'h80AD_BEEF, 2'b00, 2'd0);

      check("sb_drain", sb_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-002 SHALL provide the following ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- ins_MEM  in  32  instruction from EX/MEM
- pc_MEM  in  32  PC from EX/MEM
- alu_MEM  in  32  ALU result (effective address for load/store)
- o2_MEM  in  32  store data (rt value)
- rd_MEM  in  5  destination register
- Tnew_MEM  in  2  cycles until result ready
- ins_WB  out  32  registered instruction
- pc_WB  out  32  registered PC
- alu_WB  out  32  registered ALU result
- dm_WB  out  32  registered load data, already extended
- rd_WB  out  5  registered destination
- Tnew_WB  out  2  registered Tnew
- exc_WB  out  2  registered fault code: 00 none, 01 load fault, 10 store fault

Function
REQ-003 SHALL decode ins_MEM[31:26]:
- lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
- sw 101011, sh 101001, sb 101000
- any other opcode is a non-memory instruction.
REQ-004 SHALL contain a data memory of 1024 x 32-bit words, indexed by alu_MEM[11:2]; valid byte addresses are 0x0000-0x2FFF.
REQ-005 SHALL perform stores on the rising clk edge as byte-lane writes:
- sw: all 4 lanes.
- sh: lanes {addr[1],0} and {addr[1],1} with o2_MEM[15:0].
- sb: lane addr[1:0] with o2_MEM[7:0].
- Little-endian: byte 0 = bits 7:0.
REQ-006 SHALL read memory combinationally and select/extend the result before registering it:
- lw: whole word.
- lh: sign-extended half at addr[1].
- lhu: zero-extended half at addr[1].
- lb: sign-extended byte at addr[1:0].
- lbu: zero-extended byte at addr[1:0].
- Non-load: dm_WB = 0.
REQ-007 SHALL flag a fault when either holds:
- Misalignment: lw/sw with addr[1:0] != 0, or lh/lhu/sh with addr[0] != 0.
- Address >= 0x3000.
A faulting store writes nothing. A faulting load gives dm_WB = 0. exc_WB = 01 for a load fault, 10 for a store fault.
REQ-008 SHALL register ins, pc, alu, rd, load data and fault code every rising clk edge, giving 1-cycle latency MEM->WB. There is no stall or enable.
REQ-009 SHALL set Tnew_WB = Tnew_MEM-1 when Tnew_MEM > 0, else 0 (saturating, never wraps).
REQ-010 SHALL make a store at cycle N visible to a load of the same word at cycle N+1. Same-cycle read returns the pre-write contents.
REQ-011 SHALL treat alu_MEM[31:12] as don't-care for indexing; they participate only in the >= 0x3000 range check.

Reset
REQ-012 SHALL, while clr = 0, asynchronously force the outputs to:
- ins_WB = 0
- pc_WB = 0x00003000
- alu_WB = 0, dm_WB = 0, rd_WB = 0, Tnew_WB = 0, exc_WB = 00
REQ-013 SHALL suppress all memory writes while clr = 0, including a store that is mid-cycle when reset asserts.
REQ-014 SHALL NOT reset memory contents, which are initialised to 0 at power-up only. Reset deassertion takes effect at the next rising edge.

Structure
REQ-015 SHALL take opcode constants, the fault codes, the reset PC 0x3000 and the memory depth from a shared package, which is common with the EX-stage decoder.
REQ-016 SHALL isolate the memory array plus byte-lane write logic in one sub-module, dm_ram (ports: clk, we[3:0], addr[9:0], wdata[31:0], rdata[31:0]). Decode, extension, fault logic and the WB register stay in mem_stage.

Verification
REQ-017 Word round-trip: sw 0xDEADBEEF to 0x0010, then lw 0x0010 the next cycle -> dm_WB = 0xDEADBEEF one cycle after the lw, exc_WB = 00.
REQ-018 Sub-word: sb 0x80 to 0x0013, then:
- lb 0x0013 -> dm_WB = 0xFFFFFF80.
- lbu 0x0013 -> dm_WB = 0x00000080.
- lh 0x0012 -> upper half sign-extended, other bytes unchanged.
REQ-019 Faults:
- sw to 0x0006 -> exc_WB = 10, word 0x0004 unchanged.
- lh from 0x0011 -> exc_WB = 01, dm_WB = 0.
- lw from 0x3000 -> exc_WB = 01.
REQ-020 Tnew: Tnew_MEM = 2 -> Tnew_WB = 1. Tnew_MEM = 0 -> Tnew_WB = 0.
REQ-021 Reset mid-operation: assert clr = 0 between clock edges during an sw -> outputs go immediately to reset values (pc_WB = 0x3000) and the target word is unchanged after release.
REQ-022 Back-to-back: sh 0x1234 to 0x0020, then sh 0x5678 to 0x0022, then lw 0x0020 -> dm_WB = 0x56781234.
